// File: rtl/stft_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// stft_frame_ctrl_if
// Frame-sample stream from the STFT frame controller to the FFT core.
//   o_data  : frame sample (OUT_WIDTH bits), driven by the master
//   o_valid : o_data is valid, driven by the master
//   o_first : qualifies the first sample of a frame, driven by the master
//   o_last  : qualifies the last sample of a frame, driven by the master
//   i_ready : FFT accepts o_data, driven by the slave
// A sample transfers on a clock edge where o_valid and i_ready are both 1.
// ---------------------------------------------------------------------------
interface stft_frame_ctrl_if #(
    parameter int OUT_WIDTH = 16
) ();
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 o_first;
    logic                 o_last;
    logic                 i_ready;

    modport master (
        output o_data,
        output o_valid,
        output o_first,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_first,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/stft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// stft_frame_ctrl
// Synchronises the I2S-domain sample strobe into clk, stores every new sample
// in a circular frame buffer of FFT_SIZE entries and, every HOP samples,
// streams one full overlapping frame (oldest sample first) to the FFT.
//
// Ports
//   clk           : compute clock
//   RESET_N       : asynchronous active-low reset
//   SAMPLE_VALID  : I2S-domain level strobe, rising edge = new sample
//   i_SAMPLE      : I2S-domain sample, quasi-static around the strobe rise
//   fft           : frame stream (master side of stft_frame_ctrl_if)
//   o_frame_count : frames fully delivered (wraps)
//   o_overrun     : sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module stft_frame_ctrl #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int OUT_WIDTH    = 16,
    parameter int FFT_SIZE     = 512,
    parameter int HOP          = 128,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    RESET_N,
    input  logic                    SAMPLE_VALID,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE,
    stft_frame_ctrl_if.master       fft,
    output logic [15:0]             o_frame_count,
    output logic                    o_overrun
);

    localparam int AW  = $clog2(FFT_SIZE);
    localparam int IW  = AW + 1;
    localparam int HW  = (HOP > 1) ? $clog2(HOP) : 1;

    localparam logic [AW-1:0] A_ONE    = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(FFT_SIZE - 1);
    localparam logic [IW-1:0] I_ONE    = IW'(1);
    localparam logic [IW-1:0] N_IDX    = IW'(FFT_SIZE);
    localparam logic [IW-1:0] I_LAST   = IW'(FFT_SIZE - 1);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [HW-1:0] HOP_LAST = HW'(HOP - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // synchroniser and edge detect
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sv_hist;
    logic                   w_wr;

    // frame buffer
    logic [OUT_WIDTH-1:0]   r_mem [FFT_SIZE];
    logic [OUT_WIDTH-1:0]   r_rd_data;
    logic [OUT_WIDTH-1:0]   w_sample_trunc;

    // control state
    state_t                 r_state;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_fill_cnt;
    logic [HW-1:0]          r_hop_cnt;
    logic                   r_pending;
    logic [AW-1:0]          r_base;
    logic [IW-1:0]          r_rd_idx;
    logic                   r_rd_vld;
    logic                   r_rd_first;
    logic                   r_rd_last;

    // two-deep output queue: head drives the bus, skid catches the read in flight
    logic                   r_out_vld;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic                   r_out_first;
    logic                   r_out_last;
    logic                   r_skid_vld;
    logic [OUT_WIDTH-1:0]   r_skid_data;
    logic                   r_skid_first;
    logic                   r_skid_last;

    logic [15:0]            r_frame_cnt;
    logic                   r_overrun;

    // combinational helpers
    logic                   w_pop;
    logic                   w_frame_end;
    logic [1:0]             w_occ;
    logic                   w_rd_en;
    logic [AW-1:0]          w_rd_addr;
    logic [AW-1:0]          w_wr_off;
    logic                   w_trig;
    logic                   w_start;
    logic                   w_pend_keep;
    logic [AW-1:0]          w_base_next;
    logic                   w_ovr_stream;

    assign w_sample_trunc = i_SAMPLE[SAMPLE_WIDTH-1 -: OUT_WIDTH];

    // Low sample bits are dropped by design; fold them into an ignored net.
    generate
        if (SAMPLE_WIDTH > OUT_WIDTH) begin : g_lsb_drop
            logic w_unused_lsb;
            assign w_unused_lsb = ^i_SAMPLE[SAMPLE_WIDTH-OUT_WIDTH-1:0];
        end
    endgenerate

    // Strobe synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync    <= '0;
            r_sv_hist <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], SAMPLE_VALID};
            r_sv_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // One-cycle write event per synchronised 0->1 transition.
    assign w_wr = r_sync[SYNC_STAGES-1] & ~r_sv_hist;

    // Frame buffer: write on sample event, registered read (one-cycle latency).
    // Read and write to the same address in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_sample_trunc;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // Next-state helpers for triggers, frame launch, reads and overrun.
    always_comb begin
        w_pop       = r_out_vld & fft.i_ready;
        w_frame_end = w_pop & r_out_last;
        // entries held or in flight after this cycle's pop; reads stop at two
        w_occ       = {1'b0, r_out_vld} + {1'b0, r_skid_vld}
                    + {1'b0, r_rd_vld} - {1'b0, w_pop};
        w_rd_en     = (r_state == ST_STREAM) && (r_rd_idx < N_IDX) && (w_occ < 2'd2);
        w_rd_addr   = r_base + r_rd_idx[AW-1:0];
        w_wr_off    = r_wr_ptr - r_base;

        if (!w_wr) begin
            w_trig = 1'b0;
        end else if (r_state == ST_FILL) begin
            w_trig = (r_fill_cnt == LAST_IDX);
        end else begin
            w_trig = (r_hop_cnt == HOP_LAST);
        end

        // a pending frame launches from IDLE, or back-to-back at frame end
        w_start     = r_pending & ((r_state == ST_IDLE) | w_frame_end);
        w_pend_keep = r_pending & ~w_start;
        // a write in the launch cycle lands first, so base must include it
        w_base_next = w_wr ? (r_wr_ptr + A_ONE) : r_wr_ptr;
        // write offset at or beyond the read index hits a not-yet-read slot
        w_ovr_stream = w_wr & (r_state == ST_STREAM) & ({1'b0, w_wr_off} >= r_rd_idx);
    end

    // Main controller: FSM, counters, read pipeline and registered outputs.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= ST_FILL;
            r_wr_ptr     <= '0;
            r_fill_cnt   <= '0;
            r_hop_cnt    <= '0;
            r_pending    <= 1'b0;
            r_base       <= '0;
            r_rd_idx     <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_first   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_vld   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_first <= 1'b0;
            r_skid_last  <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + A_ONE;
            end

            case (r_state)
                ST_FILL: begin
                    if (w_wr) begin
                        r_fill_cnt <= r_fill_cnt + A_ONE;
                    end
                    if (w_trig) begin
                        r_fill_cnt <= '0;
                        r_hop_cnt  <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_wr) begin
                        r_hop_cnt <= w_trig ? '0 : (r_hop_cnt + H_ONE);
                    end
                    if (w_start) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_wr) begin
                        r_hop_cnt <= w_trig ? '0 : (r_hop_cnt + H_ONE);
                    end
                    if (w_frame_end) begin
                        r_state <= w_start ? ST_STREAM : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase

            // only one frame can be queued; a second trigger is an overrun
            r_pending <= w_pend_keep | w_trig;
            if ((w_trig & w_pend_keep) | w_ovr_stream) begin
                r_overrun <= 1'b1;
            end

            if (w_start) begin
                r_base   <= w_base_next;
                r_rd_idx <= '0;
            end else if (w_rd_en) begin
                r_rd_idx <= r_rd_idx + I_ONE;
            end

            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_first <= (r_rd_idx == '0);
                r_rd_last  <= (r_rd_idx == I_LAST);
            end

            // head refills from skid first (older), else from the read in flight
            if (!r_out_vld || w_pop) begin
                if (r_skid_vld) begin
                    r_out_vld    <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_first  <= r_skid_first;
                    r_out_last   <= r_skid_last;
                    r_skid_vld   <= r_rd_vld;
                    r_skid_data  <= r_rd_data;
                    r_skid_first <= r_rd_first;
                    r_skid_last  <= r_rd_last;
                end else if (r_rd_vld) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= r_rd_data;
                    r_out_first <= r_rd_first;
                    r_out_last  <= r_rd_last;
                end else begin
                    r_out_vld   <= 1'b0;
                    r_out_first <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end else if (r_rd_vld) begin
                r_skid_vld   <= 1'b1;
                r_skid_data  <= r_rd_data;
                r_skid_first <= r_rd_first;
                r_skid_last  <= r_rd_last;
            end

            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign fft.o_data    = r_out_data;
    assign fft.o_valid   = r_out_vld;
    assign fft.o_first   = r_out_first;
    assign fft.o_last    = r_out_last;
    assign o_frame_count = r_frame_cnt;
    assign o_overrun     = r_overrun;

endmodule

// File: doc/stft_frame_ctrl.md
Name: stft_frame_ctrl

Overview:
Parametrised successor to the STFT sample-strobe front end. It synchronises the I2S-domain sample strobe into `clk` and stores each new sample in an internal circular frame buffer of FFT_SIZE entries. Every HOP samples it streams one full overlapping frame, oldest sample first, to the FFT over a valid/ready handshake. It sits between the I2S receiver and the FFT core and replaces the bare start-pulse generator.

Parameters:
SAMPLE_WIDTH, 24, width of the incoming I2S sample.
OUT_WIDTH, 16, width of samples delivered to the FFT; must be <= SAMPLE_WIDTH.
FFT_SIZE, 512, frame length; must be a power of two, >= 4.
HOP, 128, samples between frame starts; 1 <= HOP <= FFT_SIZE.
SYNC_STAGES, 2, flops in the SAMPLE_VALID synchroniser; must be >= 2.

Ports:
clk  in  1  compute clock (27 MHz).
RESET_N  in  1  asynchronous, active-low reset.
SAMPLE_VALID  in  1  level strobe from the I2S domain; a rising edge means i_SAMPLE holds a new stable sample.
i_SAMPLE  in  SAMPLE_WIDTH  sample from the I2S domain; stable for at least SYNC_STAGES+2 clk cycles after the SAMPLE_VALID rise.
o_data  out  OUT_WIDTH  frame sample, equal to stored[SAMPLE_WIDTH-1 -: OUT_WIDTH] (truncation, no rounding).
o_valid  out  1  o_data is valid.
i_ready  in  1  FFT accepts o_data.
o_first  out  1  qualifies the first sample of a frame.
o_last  out  1  qualifies sample FFT_SIZE-1 of a frame.
o_frame_count  out  16  frames fully delivered; wraps at 65535 -> 0.
o_overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous assert, synchronous release): o_data, o_valid, o_first, o_last, o_frame_count and o_overrun are 0. Write pointer, hop counter, fill counter and pending flag are 0. Synchroniser flops are 0. State is FILL.
- Edge detect:
  - SAMPLE_VALID passes through SYNC_STAGES flops plus one history flop.
  - A sample event `wr` is a 1-cycle pulse on synchronised 0->1.
  - On `wr`, i_SAMPLE is registered directly (quasi-static), written to mem[wr_ptr], and wr_ptr increments mod FFT_SIZE.
  - A level held high produces exactly one event.
- Trigger:
  - In FILL, count writes. On the FFT_SIZE-th write, raise `pending`, clear the hop counter and go to IDLE.
  - Outside FILL, each write increments the hop counter. When it reaches HOP it clears to 0 and raises `pending`.
- Overrun on trigger: if `pending` is already set when a trigger occurs, set o_overrun. `pending` stays at 1, so there is no second queued frame.
- IDLE -> STREAM when `pending` is set.
  - At that point: base = wr_ptr, the read index is 0, and `pending` clears.
  - A write in the same cycle is applied first, so base includes it.
- STREAM:
  - Present mem[(base+k) mod FFT_SIZE] for k = 0..FFT_SIZE-1.
  - Memory read latency is one cycle. o_valid first asserts within 2 cycles of entering STREAM.
  - With i_ready held high the stream runs at one sample per cycle with no bubbles; a prefetch/skid register is required.
  - While o_valid=1 and i_ready=0, o_data, o_first and o_last hold stable.
  - o_first=1 only with k=0. o_last=1 only with k=FFT_SIZE-1.
- Frame end: on the o_last transfer, o_frame_count increments and the state goes to IDLE. If `pending` is set, go directly to STREAM instead.
- Overrun during STREAM: a write during STREAM to an address not yet read in the current frame sets o_overrun. The write still occurs, so the frame is corrupt, but the stream completes with all FFT_SIZE samples.
- o_valid never asserts in FILL or IDLE.
- RESET_N low mid-stream aborts immediately. No partial o_last is issued, and the block restarts in FILL.

Test Plan:
- FFT_SIZE=8, HOP=4, i_ready=1; samples 0x000100..0x000800 (one every 40 clk) -> after the 8th event, one frame o_data = 0x0001..0x0008, o_first on 0x0001, o_last on 0x0008, o_frame_count=1.
- Continue with samples 0x000900..0x000C00 -> second frame 0x0005..0x000C, o_frame_count=2, o_overrun=0.
- SAMPLE_VALID held high 100 cycles, then low -> exactly one write (check by frame contents).
- Same as scenario 1, but i_ready toggles 1,0,0 repeatedly -> o_data stable while stalled, frame order unchanged, 8 transfers exactly.
- i_ready=0 for the whole of two hop periods after a frame starts -> o_overrun=1 and stays 1 after i_ready returns; the frame still ends with o_last after 8 transfers.
- RESET_N pulsed low for 1 cycle at transfer k=3 -> all outputs 0 asynchronously. No o_valid until 8 new samples are received; the next frame holds only post-reset samples.
